// File: rtl/node_rf_pkg.sv
// rtl/node_rf_pkg.sv - shared widths, INF constant, sweep state and entry type for the node weight file
package node_rf_pkg;

    localparam int WEIGHT_W = 7;
    localparam int PRED_W   = 5;
    localparam int MEM_W    = WEIGHT_W + PRED_W;

    localparam logic [WEIGHT_W-1:0] INF = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

    typedef struct packed {
        logic [WEIGHT_W-1:0] weight;
        logic [PRED_W-1:0]   pred;
    } entry_t;

endpackage

// File: rtl/node_rf_wr_arbiter.sv
// rtl/node_rf_wr_arbiter.sv - per-address winner select across write ports (combinational)
module node_rf_wr_arbiter
    import node_rf_pkg::*;
#(
    parameter int NUM_WR = 4,
    parameter int ADDR_W = 5
) (
    input  logic [NUM_WR-1:0]          elig,
    input  logic [NUM_WR*ADDR_W-1:0]   addr,
    input  logic [NUM_WR*WEIGHT_W-1:0] weight,
    input  logic                       relax,
    output logic [NUM_WR-1:0]          win
);

    // A port loses to any other eligible port on the same address that beats it:
    // relax ranks by (weight, index), plain ranks by index alone.
    always_comb begin
        win = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            win[p] = elig[p];
            for (int q = 0; q < NUM_WR; q++) begin
                if (q != p && elig[q] &&
                    addr[q*ADDR_W +: ADDR_W] == addr[p*ADDR_W +: ADDR_W]) begin
                    if (relax) begin
                        if (weight[q*WEIGHT_W +: WEIGHT_W] < weight[p*WEIGHT_W +: WEIGHT_W] ||
                            (weight[q*WEIGHT_W +: WEIGHT_W] == weight[p*WEIGHT_W +: WEIGHT_W] && q < p))
                            win[p] = 1'b0;
                    end else if (q < p) begin
                        win[p] = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/node_weight_rf.sv
// rtl/node_weight_rf.sv - multi-port {weight,pred} register file with relax writes and init sweep
// Optional visited bits and mark port: NODE_RF_VISITED_EN.
module node_weight_rf
    import node_rf_pkg::*;
#(
    parameter int NUM_NODES  = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 4,
    parameter int INIT_LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_start,
    input  logic [ADDR_W-1:0]          init_src,
    output logic                       init_busy,
    output logic                       init_done,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*WEIGHT_W-1:0] rd_weight,
    output logic [NUM_RD*PRED_W-1:0]   rd_pred,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*MEM_W-1:0]    wr_data,
    input  logic                       wr_relax,
`ifdef NODE_RF_VISITED_EN
    input  logic                       mark_en,
    input  logic [ADDR_W-1:0]          mark_addr,
    output logic [NUM_RD-1:0]          rd_visited,
`endif
    output logic [NUM_WR-1:0]          wr_ack,
    output logic                       any_update
);

    localparam int SWEEP_CYCLES = NUM_NODES / INIT_LANES;
    localparam int CNT_W        = $clog2(SWEEP_CYCLES) + 1;
    localparam int IDX_W        = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SWEEP_CYCLES - 1);

    sweep_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic sweep_last;

    entry_t mem_q [NUM_NODES];
    entry_t mem_d [NUM_NODES];
    logic [NUM_NODES-1:0] vis_q, vis_d;

    logic [NUM_RD*WEIGHT_W-1:0] rd_weight_q, rd_weight_d;
    logic [NUM_RD*PRED_W-1:0]   rd_pred_q, rd_pred_d;
    logic [NUM_RD-1:0]          rd_vis_q, rd_vis_d;
    logic [NUM_WR-1:0]          ack_q, ack_d;
    logic                       any_q, any_d;

    logic [NUM_WR-1:0]          wr_elig, wr_win, wr_commit;
    logic [NUM_WR*WEIGHT_W-1:0] wr_weight;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (init_start) state_d = SWEEP;
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (sweep_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        init_busy  = (state_q == SWEEP);
        init_done  = done_q;
        sweep_last = (state_q == SWEEP) && (cnt_q == LAST_CNT);
    end

    always_comb begin
        logic [ADDR_W-1:0] wa;
        wr_elig   = '0;
        wr_weight = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wa = wr_addr[p*ADDR_W +: ADDR_W];
            wr_weight[p*WEIGHT_W +: WEIGHT_W] = wr_data[p*MEM_W + PRED_W +: WEIGHT_W];
            wr_elig[p] = wr_en[p] && (32'(wa) < NUM_NODES) && (state_q == IDLE);
`ifdef NODE_RF_VISITED_EN
            if (wr_relax && vis_q[wa[IDX_W-1:0]]) wr_elig[p] = 1'b0;
`endif
        end
    end

    node_rf_wr_arbiter #(
        .NUM_WR (NUM_WR),
        .ADDR_W (ADDR_W)
    ) u_arb (
        .elig   (wr_elig),
        .addr   (wr_addr),
        .weight (wr_weight),
        .relax  (wr_relax),
        .win    (wr_win)
    );

    // Relax winners still have to strictly beat the stored weight to commit.
    always_comb begin
        logic [IDX_W-1:0] idx;
        wr_commit = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            idx = wr_addr[p*ADDR_W +: IDX_W];
            wr_commit[p] = wr_win[p] &&
                (!wr_relax || (wr_weight[p*WEIGHT_W +: WEIGHT_W] < mem_q[idx].weight));
        end
        ack_d = wr_commit;
        any_d = |wr_commit;
    end

    always_comb begin
        logic [IDX_W-1:0] idx;
        mem_d = mem_q;
        vis_d = vis_q;
        if (state_q == SWEEP) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                if (32'(cnt_q) == 32'(n / INIT_LANES)) begin
                    mem_d[n] = '{weight: INF, pred: PRED_W'(n)};
                    vis_d[n] = 1'b0;
                end
            end
            if (sweep_last && (32'(init_src) < NUM_NODES))
                mem_d[init_src[IDX_W-1:0]] = '{weight: '0, pred: PRED_W'(init_src)};
        end
        for (int p = 0; p < NUM_WR; p++) begin
            idx = wr_addr[p*ADDR_W +: IDX_W];
            if (wr_commit[p])
                mem_d[idx] = '{weight: wr_data[p*MEM_W + PRED_W +: WEIGHT_W],
                               pred:   wr_data[p*MEM_W +: PRED_W]};
        end
`ifdef NODE_RF_VISITED_EN
        if (mark_en && (32'(mark_addr) < NUM_NODES)) vis_d[mark_addr[IDX_W-1:0]] = 1'b1;
`endif
    end

    // Reads see mem_d so a same-edge commit is returned immediately.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        entry_t e;
        rd_weight_d = '0;
        rd_pred_d   = '0;
        rd_vis_d    = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            ra = rd_addr[r*ADDR_W +: ADDR_W];
            e  = '{weight: INF, pred: '0};
            if (32'(ra) < NUM_NODES) begin
                e = mem_d[ra[IDX_W-1:0]];
                rd_vis_d[r] = vis_d[ra[IDX_W-1:0]];
            end
            rd_weight_d[r*WEIGHT_W +: WEIGHT_W] = e.weight;
            rd_pred_d[r*PRED_W +: PRED_W]       = e.pred;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            done_q      <= 1'b0;
            vis_q       <= '0;
            rd_weight_q <= '0;
            rd_pred_q   <= '0;
            rd_vis_q    <= '0;
            ack_q       <= '0;
            any_q       <= 1'b0;
            for (int n = 0; n < NUM_NODES; n++) mem_q[n] <= '{weight: INF, pred: '0};
        end else begin
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            vis_q       <= vis_d;
            rd_weight_q <= rd_weight_d;
            rd_pred_q   <= rd_pred_d;
            rd_vis_q    <= rd_vis_d;
            ack_q       <= ack_d;
            any_q       <= any_d;
            for (int n = 0; n < NUM_NODES; n++) mem_q[n] <= mem_d[n];
        end
    end

    assign rd_weight  = rd_weight_q;
    assign rd_pred    = rd_pred_q;
    assign wr_ack     = ack_q;
    assign any_update = any_q;
`ifdef NODE_RF_VISITED_EN
    assign rd_visited = rd_vis_q;
`else
    logic unused_vis;
    assign unused_vis = ^{vis_q, rd_vis_q};
`endif

endmodule

// File: tb/tb_node_weight_rf.sv
// tb/tb_node_weight_rf.sv - vector table, directed sweep/reset sequences and random model check for node_weight_rf
module tb_node_weight_rf;

    localparam int NN = 32;
    localparam int AW = 6;
    localparam int WW = 7;
    localparam int PW = 5;
    localparam int MW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              init_start;
    logic [AW-1:0]     init_src;
    logic              init_busy, init_done;
    logic [3:0][AW-1:0] ra, wa;
    logic [3:0][MW-1:0] wd;
    logic [4*WW-1:0]   rd_weight;
    logic [4*PW-1:0]   rd_pred;
    logic [3:0]        en;
    logic              relax;
    logic [3:0]        wr_ack;
    logic              any_update;

    node_weight_rf #(
        .NUM_NODES (NN), .ADDR_W (AW), .NUM_RD (4), .NUM_WR (4), .INIT_LANES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_src   (init_src),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .rd_addr    (ra),
        .rd_weight  (rd_weight),
        .rd_pred    (rd_pred),
        .wr_en      (en),
        .wr_addr    (wa),
        .wr_data    (wd),
        .wr_relax   (relax),
        .wr_ack     (wr_ack),
        .any_update (any_update)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] rd_word(input int r);
        return {rd_weight[r*WW +: WW], rd_pred[r*PW +: PW]};
    endfunction

    // Reference contents of the file, held as plain arrays.
    logic [WW-1:0] mw [NN];
    logic [PW-1:0] mp [NN];

    task automatic model_reset();
        for (int a = 0; a < NN; a++) begin mw[a] = 7'h7F; mp[a] = '0; end
    endtask

    task automatic model_sweep(input int src);
        for (int a = 0; a < NN; a++) begin mw[a] = 7'h7F; mp[a] = PW'(a); end
        mw[src] = '0;
        mp[src] = PW'(src);
    endtask

    // Per address: pick the lowest-index requester, or in relax mode the lightest
    // (first found wins ties), then relax only replaces a strictly heavier entry.
    task automatic model_step(output logic [3:0] ack, output logic [3:0][MW-1:0] rd);
        ack = '0;
        for (int a = 0; a < NN; a++) begin
            int best = -1;
            for (int p = 0; p < 4; p++) begin
                if (en[p] && int'(wa[p]) == a) begin
                    if (best < 0) best = p;
                    else if (relax && wd[p][MW-1:PW] < wd[best][MW-1:PW]) best = p;
                end
            end
            if (best >= 0 && (!relax || wd[best][MW-1:PW] < mw[a])) begin
                ack[best] = 1'b1;
                mw[a] = wd[best][MW-1:PW];
                mp[a] = wd[best][PW-1:0];
            end
        end
        for (int r = 0; r < 4; r++)
            rd[r] = (int'(ra[r]) < NN) ? {mw[ra[r]], mp[ra[r]]} : {7'h7F, 5'd0};
    endtask

    typedef struct {
        logic               relax;
        logic [3:0]         en;
        logic [3:0][AW-1:0] wa;
        logic [3:0][MW-1:0] wd;
        logic [3:0][AW-1:0] ra;
        logic [3:0]         ack;
        logic               any;
        logic [3:0][MW-1:0] rd;
    } vec_t;

    vec_t tab [5];

    initial begin
        logic [3:0] eack;
        logic [3:0][MW-1:0] erd;
        int n_busy, n_done;
        bit ack_seen, wrote;

        tab[0] = '{relax: 1'b0, en: 4'b1101, wa: {6'd3, 6'd2, 6'd1, 6'd0},
                   wd: {12'h032, 12'hE87, 12'h795, 12'h9F5}, ra: {6'd3, 6'd2, 6'd1, 6'd0},
                   ack: 4'b1101, any: 1'b1, rd: {12'h032, 12'hE87, 12'hFE1, 12'h9F5}};
        tab[1] = '{relax: 1'b1, en: 4'b1111, wa: {6'd6, 6'd6, 6'd6, 6'd6},
                   wd: {12'h3C4, 12'h183, 12'h182, 12'h281}, ra: {6'd6, 6'd6, 6'd6, 6'd6},
                   ack: 4'b0010, any: 1'b1, rd: {12'h182, 12'h182, 12'h182, 12'h182}};
        tab[2] = '{relax: 1'b1, en: 4'b0001, wa: {6'd0, 6'd0, 6'd0, 6'd6},
                   wd: {12'h0, 12'h0, 12'h0, 12'h189}, ra: {6'd6, 6'd6, 6'd6, 6'd6},
                   ack: 4'b0000, any: 1'b0, rd: {12'h182, 12'h182, 12'h182, 12'h182}};
        tab[3] = '{relax: 1'b1, en: 4'b1100, wa: {6'd8, 6'd8, 6'd0, 6'd0},
                   wd: {12'h142, 12'h141, 12'h0, 12'h0}, ra: {6'd8, 6'd8, 6'd8, 6'd8},
                   ack: 4'b0100, any: 1'b1, rd: {12'h141, 12'h141, 12'h141, 12'h141}};
        tab[4] = '{relax: 1'b0, en: 4'b0111, wa: {6'd0, 6'd32, 6'd31, 6'd4},
                   wd: {12'h0, 12'h7AB, 12'h0A6, 12'h423}, ra: {6'd5, 6'd32, 6'd31, 6'd4},
                   ack: 4'b0011, any: 1'b1, rd: {12'h005, 12'hFE0, 12'h0A6, 12'h423}};

        rst = 1'b0; init_start = 1'b0; init_src = '0;
        ra = '0; wa = '0; wd = '0; en = '0; relax = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", init_busy, 0);
        check("reset_done", init_done, 0);
        check("reset_ack", wr_ack, 0);
        check("reset_any", any_update, 0);
        check("reset_rd_weight", rd_weight, 0);

        rst = 1'b1;
        ra = {6'd3, 6'd2, 6'd1, 6'd0};
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) check($sformatf("reset_read%0d", r), rd_word(r), 12'hFE0);
        check("post_reset_busy", init_busy, 0);
        check("post_reset_ack", wr_ack, 0);
        model_reset();

        init_start = 1'b1; init_src = 6'd5;
        @(posedge clk); #1;
        init_start = 1'b0;
        check("sweep_busy_first", init_busy, 1);
        n_busy = 1; n_done = 0; ack_seen = 0; wrote = 0;
        for (int i = 0; i < 15; i++) begin
            if (n_busy == 3 && !wrote) begin
                en = 4'b0001; wa[0] = 6'd9; wd[0] = 12'h000; wrote = 1;
            end else begin
                en = '0;
            end
            @(posedge clk); #1;
            if (init_busy) n_busy++;
            if (init_done) n_done++;
            if (wr_ack != 0) ack_seen = 1;
        end
        en = '0;
        check("sweep_busy_cycles", n_busy, 8);
        check("sweep_done_pulses", n_done, 1);
        check("sweep_write_no_ack", ack_seen, 0);
        model_sweep(5);
        ra = {6'd0, 6'd0, 6'd5, 6'd9};
        @(posedge clk); #1;
        check("sweep_entry9", rd_word(0), 12'hFE9);
        check("sweep_entry5", rd_word(1), 12'h005);

        for (int v = 0; v < 5; v++) begin
            relax = tab[v].relax; en = tab[v].en; wa = tab[v].wa; wd = tab[v].wd; ra = tab[v].ra;
            model_step(eack, erd);
            @(posedge clk); #1;
            check($sformatf("vec%0d_ack", v), wr_ack, tab[v].ack);
            check($sformatf("vec%0d_any", v), any_update, tab[v].any);
            for (int r = 0; r < 4; r++)
                check($sformatf("vec%0d_rd%0d", v, r), rd_word(r), tab[v].rd[r]);
        end

        for (int i = 0; i < 400; i++) begin
            en = 4'($urandom);
            relax = 1'($urandom);
            for (int p = 0; p < 4; p++) begin
                wa[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
                wd[p] = MW'($urandom);
                ra[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
            end
            model_step(eack, erd);
            @(posedge clk); #1;
            check($sformatf("rand%0d_ack", i), wr_ack, eack);
            check($sformatf("rand%0d_any", i), any_update, |eack);
            for (int r = 0; r < 4; r++)
                check($sformatf("rand%0d_rd%0d", i, r), rd_word(r), erd[r]);
        end

        en = '0;
        init_start = 1'b1; init_src = 6'd5;
        @(posedge clk); #1;
        init_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_before", init_busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", init_busy, 0);
        check("abort_done", init_done, 0);
        check("abort_ack", wr_ack, 0);
        check("abort_any", any_update, 0);
        check("abort_rd_weight", rd_weight, 0);
        check("abort_rd_pred", rd_pred, 0);
        rst = 1'b1;
        ra = {6'd2, 6'd9, 6'd0, 6'd5};
        n_busy = 0; n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (init_busy) n_busy++;
            if (init_done) n_done++;
        end
        check("abort_entry5", rd_word(0), 12'hFE0);
        check("abort_entry9", rd_word(2), 12'hFE0);
        check("abort_no_busy", n_busy, 0);
        check("abort_no_done", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
